// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard controller: prefix bytes, FSM
// encoding, event layout and STATUS register bit positions.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam int EVT_W   = 10;
  localparam int EVT_EXT = 9;
  localparam int EVT_BRK = 8;

  localparam int STAT_NONEMPTY = 15;
  localparam int STAT_FULL     = 14;
  localparam int STAT_OVF      = 13;
  localparam int STAT_KERR     = 12;
  localparam int STAT_IRQ_EN   = 8;
  localparam int CTRL_FLUSH    = 0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  // 00 and FF are keyboard error/overrun indications, never key codes.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with flush. A push on a full FIFO is only taken when
// a pop happens in the same cycle; otherwise it is reported through o_drop.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [EVT_W-1:0] i_wdata,
  output logic [EVT_W-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [4:0]       o_count,
  output logic             o_drop
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] FULL_LEVEL = 5'(FIFO_DEPTH);

  logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [4:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_LEVEL);
  assign o_empty   = (r_count == 5'd0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~i_flush & o_full & ~w_do_pop;

  // Pointer and occupancy bookkeeping; flush overrides any push/pop.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Event storage; contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: folds E0/F0 prefixes into key events, queues
// them, and exposes DATA/STATUS/CTRL registers plus irq and clock inhibit.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter bit INHIBIT_ON_FULL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        cpu_sel,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        irq,
  output logic        ps2_clk_inhibit
);

  localparam logic [4:0] INH_LEVEL = 5'(FIFO_DEPTH - 1);

  logic        r_rx_valid_q;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nx;
  logic        r_irq_en;
  logic        r_ovf;
  logic        r_kerr;
  logic [15:0] r_rdata;
  logic        r_irq;
  logic        r_inhibit;

  logic        w_accept;
  logic        w_ctrl_wr;
  logic        w_flush;
  logic        w_data_rd;
  logic        w_stat_rd;
  logic        w_push;
  logic        w_err_set;
  kbd_evt_t    w_evt;
  logic [EVT_W-1:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic [4:0]  w_count;
  logic        w_drop;
  logic [15:0] w_status;
  logic        w_unused_wdata;

  assign w_ctrl_wr = cpu_sel & cpu_wr & cpu_addr;
  assign w_flush   = w_ctrl_wr & cpu_wdata[CTRL_FLUSH];
  // A flush in the same cycle discards the incoming byte entirely.
  assign w_accept  = rx_valid & ~r_rx_valid_q & ~w_flush;
  assign w_data_rd = cpu_sel & cpu_rd & ~cpu_addr;
  assign w_stat_rd = cpu_sel & cpu_rd & cpu_addr;
  assign w_unused_wdata = ^{cpu_wdata[15:14], cpu_wdata[11:9], cpu_wdata[7:1]};

  // Prefix folding: decide the next state and whether a key event is emitted.
  always_comb begin
    w_state_nx = r_state;
    w_push     = 1'b0;
    w_err_set  = 1'b0;
    w_evt.ext  = 1'b0;
    w_evt.brk  = 1'b0;
    w_evt.code = rx_data;
    if (w_accept) begin
      if (is_err_byte(rx_data)) begin
        w_err_set  = 1'b1;
        w_state_nx = ST_IDLE;
      end else if (rx_data == PS2_EXT) begin
        // E0 always restarts an extended sequence; a pending break is malformed.
        w_state_nx = ST_EXT;
      end else if (rx_data == PS2_BRK) begin
        w_state_nx = (r_state == ST_EXT || r_state == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else begin
        w_push     = 1'b1;
        w_evt.ext  = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        w_evt.brk  = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        w_state_nx = ST_IDLE;
      end
    end
  end

  // Edge detector on the decoder strobe and prefix FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid_q <= 1'b0;
      r_state      <= ST_IDLE;
    end else begin
      r_rx_valid_q <= rx_valid;
      r_state      <= w_flush ? ST_IDLE : w_state_nx;
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_pop  (w_data_rd),
    .i_flush(w_flush),
    .i_wdata(w_evt),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count),
    .o_drop (w_drop)
  );

  // STATUS word assembled from live state.
  always_comb begin
    w_status                = '0;
    w_status[STAT_NONEMPTY] = ~w_empty;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_OVF]      = r_ovf;
    w_status[STAT_KERR]     = r_kerr;
    w_status[STAT_IRQ_EN]   = r_irq_en;
    w_status[4:0]           = w_count;
  end

  // Control register and sticky flags; a new set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_kerr   <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= cpu_wdata[STAT_IRQ_EN];
      if (w_drop)                               r_ovf <= 1'b1;
      else if (w_ctrl_wr && cpu_wdata[STAT_OVF]) r_ovf <= 1'b0;
      if (w_err_set)                              r_kerr <= 1'b1;
      else if (w_ctrl_wr && cpu_wdata[STAT_KERR]) r_kerr <= 1'b0;
    end
  end

  // Registered read port; holds the last value when nothing is read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_data_rd) begin
      r_rdata <= w_empty ? 16'h0000 : {1'b1, 5'b0, w_head};
    end else if (w_stat_rd) begin
      r_rdata <= w_status;
    end
  end

  // Interrupt and clock-inhibit requests, registered from current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq     <= 1'b0;
      r_inhibit <= 1'b0;
    end else begin
      r_irq     <= r_irq_en & ~w_empty;
      r_inhibit <= INHIBIT_ON_FULL ? (w_count >= INH_LEVEL) : 1'b0;
    end
  end

  assign cpu_rdata       = r_rdata;
  assign irq             = r_irq;
  assign ps2_clk_inhibit = r_inhibit;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Testbench for ps2_kbd_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model of the key-event stream.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cpu_sel;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        irq;
  logic        ps2_clk_inhibit;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending prefix flags, event queue, sticky flags.
  logic [9:0] m_q[$];
  bit m_ext, m_brk, m_ovf, m_err, m_irq_en;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .INHIBIT_ON_FULL(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .cpu_sel        (cpu_sel),
    .cpu_rd         (cpu_rd),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .irq            (irq),
    .ps2_clk_inhibit(ps2_clk_inhibit)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_irq_en = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'h00 || b == 8'hFF) begin
      m_err = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1; m_brk = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic logic [15:0] model_data_read();
    if (m_q.size() == 0) return 16'h0000;
    return {1'b1, 5'b0, m_q.pop_front()};
  endfunction

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = 16'h0000;
    s[15] = (m_q.size() != 0);
    s[14] = (m_q.size() == DEPTH);
    s[13] = m_ovf;
    s[12] = m_err;
    s[8]  = m_irq_en;
    s[4:0] = 5'(m_q.size());
    return s;
  endfunction

  function automatic void model_ctrl_write(input logic [15:0] w);
    m_irq_en = w[8];
    if (w[13]) m_ovf = 0;
    if (w[12]) m_err = 0;
    if (w[0]) begin
      m_q.delete(); m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    model_byte(b);
  endtask

  task automatic cpu_read(input logic a, output logic [15:0] d);
    cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = a;
    tick();
    cpu_sel = 1'b0; cpu_rd = 1'b0; cpu_addr = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic cpu_write(input logic a, input logic [15:0] w);
    cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = w;
    tick();
    cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_wdata = 16'h0000;
    if (a) model_ctrl_write(w);
  endtask

  task automatic test_reset();
    logic [15:0] d;
    do_reset();
    checks++;
    if (cpu_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h want=0000", cpu_rdata); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    checks++;
    if (ps2_clk_inhibit !== 1'b0) begin failures++; $display("FAIL reset_inhibit got=%b want=0", ps2_clk_inhibit); end
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h want=0000", d); end
  endtask

  task automatic test_make();
    logic [15:0] d;
    cpu_write(1'b1, 16'h0100);
    send_byte(8'h1C);
    tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL make_irq got=%b want=1", irq); end
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h8101) begin failures++; $display("FAIL make_status1 got=%h want=8101", d); end
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h801C) begin failures++; $display("FAIL make_data got=%h want=801C", d); end
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h0100) begin failures++; $display("FAIL make_status0 got=%h want=0100", d); end
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL make_irq_clear got=%b want=0", irq); end
  endtask

  task automatic test_ext_break();
    logic [15:0] d;
    send_byte(8'hE0);
    send_byte(8'hF0);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h0100) begin failures++; $display("FAIL extbrk_prefix_count got=%h want=0100", d); end
    send_byte(8'h75);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h8101) begin failures++; $display("FAIL extbrk_status got=%h want=8101", d); end
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h8375) begin failures++; $display("FAIL extbrk_data got=%h want=8375", d); end
  endtask

  task automatic test_two_events();
    logic [15:0] d;
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'h6B);
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h811C) begin failures++; $display("FAIL two_ev_first got=%h want=811C", d); end
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h826B) begin failures++; $display("FAIL two_ev_second got=%h want=826B", d); end
    cpu_read(1'b0, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL two_ev_empty got=%h want=0000", d); end
  endtask

  task automatic test_full_overflow();
    logic [15:0] d;
    logic [15:0] e;
    cpu_write(1'b1, 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(8'h10 + 8'(i));
      tick();
      checks++;
      if (ps2_clk_inhibit !== ((i + 1) >= DEPTH - 1)) begin
        failures++; $display("FAIL full_inhibit count=%0d got=%b want=%b", i + 1, ps2_clk_inhibit, (i + 1) >= DEPTH - 1);
      end
    end
    send_byte(8'h55);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'hE008) begin failures++; $display("FAIL full_ovf_status got=%h want=E008", d); end
    cpu_write(1'b1, 16'h2000);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'hC008) begin failures++; $display("FAIL full_ovf_clear got=%h want=C008", d); end
    // push on full together with a DATA read
    rx_data = 8'h66; rx_valid = 1'b1;
    cpu_sel = 1'b1; cpu_rd = 1'b1; cpu_addr = 1'b0;
    tick();
    rx_valid = 1'b0; cpu_sel = 1'b0; cpu_rd = 1'b0;
    d = cpu_rdata;
    e = model_data_read();
    model_byte(8'h66);
    tick();
    checks++;
    if (d !== e) begin failures++; $display("FAIL full_pushpop_data got=%h want=%h", d, e); end
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'hC008) begin failures++; $display("FAIL full_pushpop_status got=%h want=C008", d); end
    for (int i = 0; i < DEPTH; i++) begin
      cpu_read(1'b0, d);
      e = model_data_read();
      checks++;
      if (d !== e) begin failures++; $display("FAIL full_drain idx=%0d got=%h want=%h", i, d, e); end
    end
    tick();
    checks++;
    if (ps2_clk_inhibit !== 1'b0) begin failures++; $display("FAIL full_inhibit_release got=%b want=0", ps2_clk_inhibit); end
  endtask

  task automatic test_reset_mid_and_err();
    logic [15:0] d;
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h1C);
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h801C) begin failures++; $display("FAIL midreset_data got=%h want=801C", d); end
    send_byte(8'hFF);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h1000) begin failures++; $display("FAIL err_status got=%h want=1000", d); end
    cpu_write(1'b1, 16'h1000);
    rx_data = 8'h2A; rx_valid = 1'b1;
    repeat (5) tick();
    rx_valid = 1'b0;
    tick();
    model_byte(8'h2A);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h8001) begin failures++; $display("FAIL hold_status got=%h want=8001", d); end
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h802A) begin failures++; $display("FAIL hold_data got=%h want=802A", d); end
  endtask

  task automatic test_flush();
    logic [15:0] d;
    send_byte(8'h11);
    send_byte(8'h22);
    cpu_write(1'b1, 16'h0001);
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL flush_status got=%h want=0000", d); end
    // flush collides with a byte accept: byte must vanish
    rx_data = 8'h33; rx_valid = 1'b1;
    cpu_sel = 1'b1; cpu_wr = 1'b1; cpu_addr = 1'b1; cpu_wdata = 16'h0001;
    tick();
    rx_valid = 1'b0; cpu_sel = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_wdata = 16'h0000;
    model_ctrl_write(16'h0001);
    tick();
    cpu_read(1'b1, d);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL flush_accept_status got=%h want=0000", d); end
    send_byte(8'hE0);
    cpu_write(1'b1, 16'h0001);
    send_byte(8'h1C);
    cpu_read(1'b0, d);
    void'(model_data_read());
    checks++;
    if (d !== 16'h801C) begin failures++; $display("FAIL flush_prefix_data got=%h want=801C", d); end
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [15:0] e;
    logic [15:0] w;
    logic [7:0]  b;
    int          sel;
    for (int it = 0; it < 400; it++) begin
      tick();
      checks++;
      if (irq !== (m_irq_en && m_q.size() != 0)) begin
        failures++; $display("FAIL rand_irq it=%0d got=%b want=%b", it, irq, m_irq_en && m_q.size() != 0);
      end
      checks++;
      if (ps2_clk_inhibit !== (m_q.size() >= DEPTH - 1)) begin
        failures++; $display("FAIL rand_inhibit it=%0d got=%b want=%b", it, ps2_clk_inhibit, m_q.size() >= DEPTH - 1);
      end
      sel = int'($urandom_range(0, 19));
      if (sel < 10) begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'hE0;
          2, 3:    b = 8'hF0;
          4:       b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h5A;
          5:       b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h29;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_byte(b);
      end else if (sel < 15) begin
        cpu_read(1'b0, d);
        e = model_data_read();
        checks++;
        if (d !== e) begin failures++; $display("FAIL rand_data it=%0d got=%h want=%h", it, d, e); end
      end else if (sel < 18) begin
        cpu_read(1'b1, d);
        e = model_status();
        checks++;
        if (d !== e) begin failures++; $display("FAIL rand_status it=%0d got=%h want=%h", it, d, e); end
      end else begin
        w = 16'h0000;
        w[8]  = 1'($urandom_range(0, 1));
        w[13] = 1'($urandom_range(0, 1));
        w[12] = 1'($urandom_range(0, 1));
        w[0]  = ($urandom_range(0, 5) == 0);
        cpu_write(1'($urandom_range(0, 1)), w);
      end
    end
  endtask

  initial begin
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cpu_sel = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 1'b0; cpu_wdata = 16'h0000;
    model_reset();
    test_reset();
    test_make();
    test_ext_break();
    test_two_events();
    test_full_overflow();
    test_reset_mid_and_err();
    test_flush();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Keyboard controller that sits between the PS/2 byte decoder and the 68k bus.
- Consumes received scan-code bytes and folds E0 (extended) and F0 (break) prefixes into single key events.
- Buffers events in a small FIFO.
- Exposes data/status registers with an interrupt to the CPU.
- Drives a PS/2 clock-inhibit request when the FIFO is nearly full.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..16.
- INHIBIT_ON_FULL, 1, when 1, ps2_clk_inhibit asserts at count >= FIFO_DEPTH-1; when 0, it is tied to 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  decoder byte-ready level; a rising edge means one new byte.
- rx_data  in  8  decoder byte, stable while rx_valid=1.
- cpu_sel  in  1  register access strobe.
- cpu_rd  in  1  read qualifier (with cpu_sel).
- cpu_wr  in  1  write qualifier (with cpu_sel).
- cpu_addr  in  1  0 = DATA, 1 = STATUS/CTRL.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  registered read data.
- irq  out  1  registered interrupt request.
- ps2_clk_inhibit  out  1  request that the PS/2 clock line be held low.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: cpu_rdata=0, irq=0, ps2_clk_inhibit=0, FIFO empty, FSM in IDLE, irq_en=0, overflow=0, kbd_err=0, rx_valid_q=0.
- Byte accept: a byte is accepted in the cycle where rx_valid=1 and rx_valid_q=0. rx_valid_q is rx_valid registered. Exactly one accept per rising edge.
- FSM states: IDLE, EXT, BRK, EXT_BRK. All transitions happen only on accept.
  - IDLE: E0 -> EXT. F0 -> BRK. 00 or FF -> set kbd_err, discard, stay IDLE. Any other byte -> push {ext=0, brk=0, code}.
  - EXT: F0 -> EXT_BRK. E0 -> stay EXT. Other -> push {ext=1, brk=0, code}, go IDLE.
  - BRK: F0 -> stay BRK. E0 -> EXT (flags dropped as malformed). Other -> push {0, 1, code}, go IDLE.
  - EXT_BRK: F0 -> stay. E0 -> EXT. Other -> push {1, 1, code}, go IDLE.
  - 00/FF in a non-IDLE state: set kbd_err, discard, go IDLE.
- Event format: 10 bits, {ext, brk, code[7:0]}.
- Push timing: the FIFO is written at the end of the accept cycle; the event is visible at the head the next cycle.
- Full FIFO: the push is dropped, overflow is set (sticky), and the FSM still goes IDLE.
- DATA read (cpu_sel & cpu_rd & addr=0):
  - Next cycle, cpu_rdata = {nonempty, 5'b0, ext, brk, code}.
  - The head is popped in the same cycle.
  - If empty: cpu_rdata = 0 and no pointer change.
- STATUS read (addr=1): cpu_rdata = {nonempty[15], full[14], overflow[13], kbd_err[12], 3'b0, irq_en[8], 3'b0, count[4:0]}, registered, no side effects.
- cpu_rdata holds its value when there is no read.
- CTRL write (cpu_sel & cpu_wr & addr=1):
  - bit8 -> irq_en.
  - bit13 = 1 clears overflow; bit12 = 1 clears kbd_err.
  - bit0 = 1 flushes the FIFO and returns the FSM to IDLE.
- A write to addr=0 is ignored. Simultaneous cpu_rd and cpu_wr: the write takes effect and the read returns the pre-write state.
- Simultaneous push and pop: both occur and count is unchanged. Push on full while a pop happens in the same cycle is accepted, with no overflow.
- Flush in the same cycle as an accept: the flush wins and the byte is discarded.
- Flag set and w1c clear in the same cycle: set wins.
- count: 5-bit, 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- irq: registered, equals irq_en & nonempty, one cycle after the condition.
- ps2_clk_inhibit: registered from count. It deasserts one cycle after count drops below FIFO_DEPTH-1.
- Reset mid-sequence (e.g. after E0): all state is cleared and the next plain byte gives a plain make event.

Decomposition:
- Package ps2_pkg holds:
  - byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF;
  - FSM state encoding;
  - event field positions (EVT_EXT=9, EVT_BRK=8);
  - STATUS bit indices.
- Sub-module ps2_event_fifo: synchronous FIFO with push/pop/flush, full/empty/count, and FIFO_DEPTH × 10-bit storage.

Test Plan:
1. Byte 1C -> DATA read returns 16'h801C; STATUS count goes 1 -> 0; irq follows irq_en=1.
2. Bytes E0 F0 75 -> single event; DATA = 16'h8375; no events are pushed for the prefixes.
3. F0 1C, then E0 6B -> two reads give 16'h811C, then 16'h826B.
4. Push 8 events with no read (DEPTH=8) -> ps2_clk_inhibit asserts at count 7; the 9th byte is dropped; STATUS bit13 = 1; writing 16'h2000 clears it.
5. Push on full in the same cycle as a DATA read -> count stays 8, overflow stays 0.
6. Send E0, then reset, then 1C -> DATA = 16'h801C. Byte FF -> kbd_err = 1, no event. Holding rx_valid high for 5 cycles yields exactly one event.
